vga_scandoubler: RTL and testbench

Line-doubling stage directly downstream of the Spectrum core. It takes the core's 15 kHz RGB333 pixel stream and separate/composite syncs, stores each input line in a ping-pong line buffer, and replays every stored line twice at double pixel rate, giving 31 kHz VGA-compatible timing. When doubling is disabled it forwards the core's native RGB and composite sync instead. It runs entirely in the 28 MHz system clock domain, using a pixel clock-enable from the core.

---
 rtl/vga_scandoubler.sv | 150 +++++++++++++++
 tb/tb_vga_scandoubler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scandoubler.sv
// Doubles 15 kHz RGB333 lines into 31 kHz VGA timing using a ping-pong line buffer, or passes native video through.
// Latency: replay output 3 clk after the input hsync fall; passthrough 1 clk.
// Backpressure: none; the pixel stream is free-running and paced by pixel_ce.
module vga_scandoubler #(
    parameter int AW      = 9,
    parameter int HSYNC_W = 54
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_scandoubling,
    input  logic       pixel_ce,
    input  logic [2:0] ri,
    input  logic [2:0] gi,
    input  logic [2:0] bi,
    input  logic       hsync_n_in,
    input  logic       vsync_n_in,
    input  logic       csync_n_in,
    output logic [2:0] ro,
    output logic [2:0] go,
    output logic [2:0] bo,
    output logic       hsync_n_out,
    output logic       vsync_n_out
);

    localparam int              DEPTH   = 1 << AW;
    localparam logic [AW-1:0]   CNT_MAX = '1;
    localparam logic [AW-1:0]   ONE     = AW'(1);
    localparam int unsigned     HS_W    = HSYNC_W;

    logic          hs_d;
    logic          boundary;
    logic          wbank;
    logic          armed;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] line_len;
    logic          line_valid;
    logic          rd_phase;

    logic          we;
    logic [AW:0]   waddr;
    logic [AW:0]   raddr;
    logic [8:0]    mem [0:2*DEPTH-1];
    logic [8:0]    rd_dat;

    logic          hs_active;
    logic          p1_valid;
    logic          p1_hs;
    logic          p1_vs;

    // Edge-detect register needs no reset: tracking the pin keeps a held-low
    // hsync from looking like a fresh line start when reset releases.
    always_ff @(posedge clk) begin
        hs_d <= hsync_n_in;
    end

    always_comb begin
        boundary = hs_d & ~hsync_n_in;
        we       = 1'b0;
        waddr    = {wbank, wr_cnt};
        if (rst) begin
            we = 1'b0;
        end else if (boundary) begin
            we    = pixel_ce;
            waddr = {~wbank, {AW{1'b0}}};
        end else begin
            we = pixel_ce & armed & (wr_cnt != CNT_MAX);
        end
        raddr     = {~wbank, rd_cnt};
        hs_active = {{(32-AW){1'b0}}, rd_cnt} < HS_W;
    end

    // armed stays low after reset so the partial line in flight is never stored
    always_ff @(posedge clk) begin
        if (rst) begin
            wbank      <= 1'b0;
            armed      <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            rd_phase   <= 1'b0;
            line_len   <= '0;
            line_valid <= 1'b0;
        end else if (boundary) begin
            wbank      <= ~wbank;
            armed      <= 1'b1;
            line_len   <= wr_cnt;
            line_valid <= (wr_cnt != '0);
            wr_cnt     <= pixel_ce ? ONE : '0;
            rd_cnt     <= '0;
            rd_phase   <= 1'b0;
        end else begin
            if (we) begin
                wr_cnt <= wr_cnt + ONE;
            end
            rd_phase <= ~rd_phase;
            if (!line_valid) begin
                rd_cnt <= '0;
            end else if (rd_phase) begin
                rd_cnt <= (rd_cnt >= line_len - ONE) ? '0 : rd_cnt + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= {ri, gi, bi};
        end
        rd_dat <= mem[raddr];
    end

    // Sync stage 1 runs alongside the RAM read so syncs stay aligned with colour
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid <= 1'b0;
            p1_hs    <= 1'b1;
            p1_vs    <= 1'b1;
        end else begin
            p1_valid <= line_valid;
            p1_hs    <= ~hs_active;
            p1_vs    <= vsync_n_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ro          <= '0;
            go          <= '0;
            bo          <= '0;
            hsync_n_out <= 1'b1;
            vsync_n_out <= 1'b1;
        end else if (!enable_scandoubling) begin
            ro          <= ri;
            go          <= gi;
            bo          <= bi;
            hsync_n_out <= csync_n_in;
            vsync_n_out <= 1'b1;
        end else if (p1_valid) begin
            {ro, go, bo} <= rd_dat;
            hsync_n_out  <= p1_hs;
            vsync_n_out  <= p1_vs;
        end else begin
            ro          <= '0;
            go          <= '0;
            bo          <= '0;
            hsync_n_out <= 1'b1;
            vsync_n_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_scandoubler.sv
// Directed bench for vga_scandoubler: line replay, sync width, overlong and truncated lines, passthrough, reset.
module tb_vga_scandoubler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_scandoubling;
    logic       pixel_ce;
    logic [2:0] ri, gi, bi;
    logic       hsync_n_in, vsync_n_in, csync_n_in;
    logic [2:0] ro, go, bo;
    logic       hsync_n_out, vsync_n_out;

    int errors = 0;
    int checks = 0;
    int hs_low;
    int hs_falls;

    always #5 clk = ~clk;

    vga_scandoubler dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable_scandoubling (enable_scandoubling),
        .pixel_ce            (pixel_ce),
        .ri                  (ri),
        .gi                  (gi),
        .bi                  (bi),
        .hsync_n_in          (hsync_n_in),
        .vsync_n_in          (vsync_n_in),
        .csync_n_in          (csync_n_in),
        .ro                  (ro),
        .go                  (go),
        .bo                  (bo),
        .hsync_n_out         (hsync_n_out),
        .vsync_n_out         (vsync_n_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] pix(input int v);
        return 9'(v % 512);
    endfunction

    // Line cycle m: hsync low for cycles 0..31, one pixel every 4 cycles at phase ce_ph
    task automatic drive_cycle(input int m, input int off, input int ce_ph, input int vs_lo);
        int k;
        k = m / 4;
        pixel_ce     = (m % 4 == ce_ph);
        {ri, gi, bi} = pix(k + off);
        hsync_n_in   = (m >= 32);
        vsync_n_in   = !(vs_lo >= 0 && m >= vs_lo && m < vs_lo + 10);
        csync_n_in   = hsync_n_in;
    endtask

    // mode 0: drive only; 1: expect black with syncs high; 2: expect replay of a stored line
    task automatic run_line(input string name, input int first, input int last, input int off,
                            input int ce_ph, input int mode, input int exp_len, input int exp_off,
                            input int vs_lo);
        logic [10:0] got, expv;
        logic        prev_hs;
        int          j;
        hs_low   = 0;
        hs_falls = 0;
        prev_hs  = 1'b1;
        for (int m = 4 * first; m < 4 * last; m++) begin
            drive_cycle(m, off, ce_ph, vs_lo);
            got = {ro, go, bo, hsync_n_out, vsync_n_out};
            if (mode != 0 && m >= 3) begin
                if (mode == 1) begin
                    expv = {9'd0, 1'b1, 1'b1};
                end else begin
                    j    = ((m - 3) / 2) % exp_len;
                    expv = {pix(j + exp_off), 1'(j >= 54),
                            1'(!(vs_lo >= 0 && m - 2 >= vs_lo && m - 2 < vs_lo + 10))};
                end
                checks++;
                if (got !== expv) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %h expected %h", name, m, got, expv);
                end
                if (!hsync_n_out) hs_low++;
                if (prev_hs && !hsync_n_out) hs_falls++;
            end
            prev_hs = hsync_n_out;
            tick;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        enable_scandoubling = 1'b1;
        pixel_ce = 1'b1;
        {ri, gi, bi} = 9'h1ff;
        hsync_n_in = 1'b1;
        vsync_n_in = 1'b0;
        csync_n_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if ({ro, go, bo, hsync_n_out, vsync_n_out} !== 11'b00000000011) begin
                errors++;
                $display("FAIL reset_state: got %h expected 003", {ro, go, bo, hsync_n_out, vsync_n_out});
            end
        end
        rst = 1'b0;
        pixel_ce = 1'b0;
        vsync_n_in = 1'b1;
        csync_n_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            checks++;
            if ({ro, go, bo, hsync_n_out, vsync_n_out} !== 11'b00000000011) begin
                errors++;
                $display("FAIL idle_after_reset: got %h expected 003", {ro, go, bo, hsync_n_out, vsync_n_out});
            end
        end
    endtask

    task automatic test_ramp;
        run_line("ramp_first_line_blank", 0, 448, 0, 1, 1, 0, 0, -1);
        run_line("ramp_replay", 0, 448, 0, 1, 2, 448, 0, 100);
    endtask

    task automatic test_sync_width;
        run_line("sync_line", 0, 448, 0, 1, 2, 448, 0, -1);
        checks++;
        if (hs_low != 216) begin
            errors++;
            $display("FAIL sync_low_cycles: got %0d expected 216", hs_low);
        end
        checks++;
        if (hs_falls != 2) begin
            errors++;
            $display("FAIL sync_pulses_per_line: got %0d expected 2", hs_falls);
        end
    endtask

    task automatic test_ce_boundary;
        run_line("ce_fill", 0, 100, 300, 0, 0, 0, 0, -1);
        run_line("ce_replay", 0, 100, 0, 0, 2, 100, 300, -1);
    endtask

    task automatic test_truncate;
        run_line("trunc_fill", 0, 448, 0, 1, 0, 0, 0, -1);
        run_line("trunc_cut", 0, 100, 5, 1, 2, 448, 0, -1);
        run_line("trunc_restart", 0, 100, 5, 1, 2, 100, 5, -1);
    endtask

    task automatic test_overlong;
        run_line("long_fill", 0, 600, 0, 1, 0, 0, 0, -1);
        run_line("long_replay", 0, 600, 0, 1, 2, 511, 0, -1);
        checks++;
        if (hs_falls != 3) begin
            errors++;
            $display("FAIL long_pass_count: got %0d expected 3", hs_falls);
        end
    endtask

    task automatic test_passthrough;
        logic [9:0] prev;
        enable_scandoubling = 1'b0;
        hsync_n_in = 1'b1;
        prev = '0;
        for (int i = 0; i < 200; i++) begin
            if (i > 0) begin
                checks++;
                if ({ro, go, bo, hsync_n_out, vsync_n_out} !== {prev, 1'b1}) begin
                    errors++;
                    $display("FAIL passthrough cycle %0d: got %h expected %h", i,
                             {ro, go, bo, hsync_n_out, vsync_n_out}, {prev, 1'b1});
                end
            end
            pixel_ce   = (i % 4 == 1);
            ri         = 3'($urandom_range(7));
            gi         = 3'($urandom_range(7));
            bi         = 3'($urandom_range(7));
            csync_n_in = 1'($urandom_range(1));
            vsync_n_in = 1'($urandom_range(1));
            prev       = {ri, gi, bi, csync_n_in};
            tick;
        end
        enable_scandoubling = 1'b1;
        vsync_n_in = 1'b1;
    endtask

    task automatic test_reset_midline;
        run_line("mid_fill", 0, 448, 0, 1, 0, 0, 0, -1);
        run_line("mid_before_reset", 0, 200, 50, 1, 2, 448, 0, -1);
        drive_cycle(800, 50, 1, -1);
        rst = 1'b1;
        tick;
        checks++;
        if ({ro, go, bo, hsync_n_out, vsync_n_out} !== 11'b00000000011) begin
            errors++;
            $display("FAIL mid_reset_black: got %h expected 003", {ro, go, bo, hsync_n_out, vsync_n_out});
        end
        rst = 1'b0;
        run_line("mid_rest_blank", 201, 448, 50, 1, 1, 0, 0, -1);
        run_line("post_reset_1st_blank", 0, 448, 77, 1, 1, 0, 0, -1);
        run_line("post_reset_2nd_replay", 0, 448, 0, 1, 2, 448, 77, -1);
    endtask

    initial begin
        rst = 1'b1;
        enable_scandoubling = 1'b1;
        pixel_ce = 1'b0;
        {ri, gi, bi} = '0;
        hsync_n_in = 1'b1;
        vsync_n_in = 1'b1;
        csync_n_in = 1'b1;
        test_reset;
        test_ramp;
        test_sync_width;
        test_ce_boundary;
        test_truncate;
        test_overlong;
        test_passthrough;
        test_reset_midline;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
